// File: rtl/mac_array_pkg.sv
// Shared MAC-array definitions: default geometry and the weight-loader state encoding.
package mac_array_pkg;

    localparam int unsigned ROW_NUM_DEF           = 16;
    localparam int unsigned WEIGHT_WIDTH_DEF      = 8;
    localparam int unsigned BUFFER_ADDR_WIDTH_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_WAIT_SET = 3'd3,
        ST_SET      = 3'd4
    } loader_state_e;

endpackage

// File: rtl/mac_weight_loader.sv
// Column weight loader: reads ROW_NUM weight pairs, shifts them down the chain, then pulses set_weight.
// Optional MAC_WEIGHT_LOADER_ZERO_PAD_EN adds i_valid_rows; rows at or above it load zero pairs.
module mac_weight_loader
    import mac_array_pkg::*;
#(
    parameter int unsigned ROW_NUM           = ROW_NUM_DEF,
    parameter int unsigned WEIGHT_WIDTH      = WEIGHT_WIDTH_DEF,
    parameter int unsigned BUFFER_ADDR_WIDTH = BUFFER_ADDR_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_start,
    input  logic [BUFFER_ADDR_WIDTH-1:0]   i_base_addr,
    input  logic                           i_set_allow,
`ifdef MAC_WEIGHT_LOADER_ZERO_PAD_EN
    input  logic [$clog2(ROW_NUM):0]       i_valid_rows,
`endif
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_buf_rd_en,
    output logic [BUFFER_ADDR_WIDTH-1:0]   o_buf_rd_addr,
    input  logic [2*WEIGHT_WIDTH-1:0]      i_buf_rd_data,
    output logic                           o_prepare_weight,
    output logic [WEIGHT_WIDTH-1:0]        o_load_weight_data_0,
    output logic [WEIGHT_WIDTH-1:0]        o_load_weight_data_1,
    output logic                           o_set_weight
);

    localparam int unsigned CNT_W = $clog2(ROW_NUM);
    localparam int unsigned AW    = BUFFER_ADDR_WIDTH;
    localparam int unsigned WW    = WEIGHT_WIDTH;

    loader_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           rd_en_q, rd_en_d;
    logic           prep_q, prep_d;
    logic           busy_q, busy_d;
    logic           set_q, set_d;
    logic [CNT_W-1:0] row_nxt;
    logic           pass_en;

`ifdef MAC_WEIGHT_LOADER_ZERO_PAD_EN
    localparam int unsigned VR_W = CNT_W + 1;
    logic [VR_W-1:0] valid_q, valid_d;
    logic [VR_W-1:0] valid_clamp;
    logic            slot_q, slot_d;
    logic            zero_q, zero_d;
`endif

    // Next-state, counter and address computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rd_en_d = 1'b0;
        set_d   = 1'b0;
        row_nxt = cnt_q - CNT_W'(1);
`ifdef MAC_WEIGHT_LOADER_ZERO_PAD_EN
        valid_d     = valid_q;
        slot_d      = 1'b0;
        valid_clamp = (i_valid_rows > VR_W'(ROW_NUM)) ? VR_W'(ROW_NUM) : i_valid_rows;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_FETCH;
                    cnt_d   = CNT_W'(ROW_NUM - 1);
`ifdef MAC_WEIGHT_LOADER_ZERO_PAD_EN
                    // Reads cover only the valid rows, starting from the highest one
                    slot_d  = 1'b1;
                    valid_d = i_valid_rows;
                    addr_d  = i_base_addr + AW'(valid_clamp) - AW'(1);
                    rd_en_d = VR_W'(ROW_NUM - 1) < i_valid_rows;
`else
                    addr_d  = i_base_addr + AW'(ROW_NUM - 1);
                    rd_en_d = 1'b1;
`endif
                end
            end
            ST_FETCH: begin
                if (rd_en_q && (cnt_q != '0)) begin
                    addr_d = addr_q - AW'(1);
                end
                if (cnt_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d   = row_nxt;
`ifdef MAC_WEIGHT_LOADER_ZERO_PAD_EN
                    slot_d  = 1'b1;
                    rd_en_d = VR_W'(row_nxt) < valid_q;
`else
                    rd_en_d = 1'b1;
`endif
                end
            end
            ST_DRAIN: begin
                state_d = ST_WAIT_SET;
            end
            ST_WAIT_SET: begin
                if (i_set_allow) begin
                    state_d = ST_SET;
                    set_d   = 1'b1;
                end
            end
            ST_SET: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
`ifdef MAC_WEIGHT_LOADER_ZERO_PAD_EN
        prep_d = slot_q;
        zero_d = slot_q & ~rd_en_q;
`else
        prep_d = rd_en_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            prep_q  <= 1'b0;
            busy_q  <= 1'b0;
            set_q   <= 1'b0;
`ifdef MAC_WEIGHT_LOADER_ZERO_PAD_EN
            valid_q <= '0;
            slot_q  <= 1'b0;
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            prep_q  <= prep_d;
            busy_q  <= busy_d;
            set_q   <= set_d;
`ifdef MAC_WEIGHT_LOADER_ZERO_PAD_EN
            valid_q <= valid_d;
            slot_q  <= slot_d;
            zero_q  <= zero_d;
`endif
        end
    end

    // Buffer data flows straight to the chain head only during real read slots
`ifdef MAC_WEIGHT_LOADER_ZERO_PAD_EN
    assign pass_en = prep_q & ~zero_q;
`else
    assign pass_en = prep_q;
`endif

    assign o_busy               = busy_q;
    assign o_done               = set_q;
    assign o_set_weight         = set_q;
    assign o_buf_rd_en          = rd_en_q;
    assign o_buf_rd_addr        = addr_q;
    assign o_prepare_weight     = prep_q;
    assign o_load_weight_data_0 = pass_en ? i_buf_rd_data[WW-1:0]    : '0;
    assign o_load_weight_data_1 = pass_en ? i_buf_rd_data[2*WW-1:WW] : '0;

endmodule
